// File: rtl/dht11_poll_ctrl.sv
// -----------------------------------------------------------------------------
// dht11_poll_ctrl
// Scheduler in front of a DHT11 frame reader core. Starts a read every
// POLL_CYCLES, or on request once GAP_CYCLES have passed since the previous
// start. Each read is checked for timeout and checksum. Failed reads are
// retried after a GAP_CYCLES back-off, up to MAX_RETRY attempts per sample.
//
// Ports
//   clk           in   single clock
//   reset_n       in   asynchronous active-low reset
//   rd_req        in   one-cycle on-demand read request
//   core_start    out  one-cycle start pulse to the reader core
//   core_done     in   reader core frame-complete level
//   core_data     in   {hum_int, hum_dec, tmp_int, tmp_dec, csum}
//   humidity      out  last good hum_int
//   temperature   out  last good tmp_int
//   sample_valid  out  pulse: new good sample latched
//   data_ok       out  at least one good sample held
//   err_timeout   out  pulse: core did not finish in time
//   err_csum      out  pulse: checksum mismatch
//   fail          out  pulse: all attempts for this sample failed
//   err_count     out  saturating count of all errors
//   busy          out  a read sequence is in progress
// -----------------------------------------------------------------------------
module dht11_poll_ctrl #(
   parameter int unsigned POLL_CYCLES    = 24_000_000,
   parameter int unsigned GAP_CYCLES     = 12_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 360_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_req,
   output logic        core_start,
   input  logic        core_done,
   input  logic [39:0] core_data,
   output logic [7:0]  humidity,
   output logic [7:0]  temperature,
   output logic        sample_valid,
   output logic        data_ok,
   output logic        err_timeout,
   output logic        err_csum,
   output logic        fail,
   output logic [7:0]  err_count,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CHECK,
      S_BACKOFF
   } state_t;

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [24:0]       POLL_LIM   = 25'(POLL_CYCLES);
   localparam logic [24:0]       GAP_LIM    = 25'(GAP_CYCLES);
   localparam logic [WAIT_W-1:0] TO_LAST    = WAIT_W'(TIMEOUT_CYCLES - 1);
   // wait_cnt is 1 and 2 in the first two S_WAIT cycles
   localparam logic [WAIT_W-1:0] FLUSH_LAST = WAIT_W'(2);
   localparam logic [2:0]        RETRY_LIM  = 3'(MAX_RETRY);

   state_t            state_q, state_d;
   logic [24:0]       ivl_cnt_q, ivl_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [2:0]        retry_cnt_q, retry_cnt_d;
   logic              pending_q, pending_d;
   logic [39:0]       frame_q, frame_d;
   logic              fail_arm_q, fail_arm_d;

   logic              core_start_q, core_start_d;
   logic [7:0]        humidity_q, humidity_d;
   logic [7:0]        temperature_q, temperature_d;
   logic              sample_valid_q, sample_valid_d;
   logic              data_ok_q, data_ok_d;
   logic              err_timeout_q, err_timeout_d;
   logic              err_csum_q, err_csum_d;
   logic              fail_q, fail_d;
   logic [7:0]        err_count_q, err_count_d;
   logic              busy_q, busy_d;

   logic [7:0]        csum_calc;
   logic [2:0]        retry_next;
   logic              err_path;

   always_comb begin
      state_d        = state_q;
      ivl_cnt_d      = (ivl_cnt_q >= POLL_LIM) ? ivl_cnt_q : ivl_cnt_q + 25'd1;
      wait_cnt_d     = '0;
      retry_cnt_d    = retry_cnt_q;
      pending_d      = pending_q | rd_req;
      frame_d        = frame_q;
      fail_arm_d     = 1'b0;
      humidity_d     = humidity_q;
      temperature_d  = temperature_q;
      sample_valid_d = 1'b0;
      data_ok_d      = data_ok_q;
      err_timeout_d  = 1'b0;
      err_csum_d     = 1'b0;
      err_count_d    = err_count_q;
      err_path       = 1'b0;
      retry_next     = retry_cnt_q + 3'd1;
      csum_calc      = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

      case (state_q)
         S_IDLE: begin
            // Periodic and on-demand triggers merge into one start
            if ((ivl_cnt_q >= POLL_LIM) || (pending_q && (ivl_cnt_q >= GAP_LIM))) begin
               state_d   = S_START;
               ivl_cnt_d = '0;
            end
         end
         S_START: begin
            // Any request seen during the start cycle is served by this read
            pending_d  = 1'b0;
            wait_cnt_d = WAIT_W'(1);
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            // Done wins over a simultaneous timeout; a done level left over
            // from the previous frame is ignored for the first two cycles.
            if (core_done && (wait_cnt_q > FLUSH_LAST)) begin
               frame_d = core_data;
               state_d = S_CHECK;
            end else if (wait_cnt_q >= TO_LAST) begin
               err_timeout_d = 1'b1;
               err_path      = 1'b1;
            end
         end
         S_CHECK: begin
            if (csum_calc == frame_q[7:0]) begin
               humidity_d     = frame_q[39:32];
               temperature_d  = frame_q[23:16];
               sample_valid_d = 1'b1;
               data_ok_d      = 1'b1;
               retry_cnt_d    = '0;
               state_d        = S_IDLE;
            end else begin
               err_csum_d = 1'b1;
               err_path   = 1'b1;
            end
         end
         S_BACKOFF: begin
            if (ivl_cnt_q >= GAP_LIM) begin
               state_d   = S_START;
               ivl_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (err_path) begin
         err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
         if (retry_next < RETRY_LIM) begin
            retry_cnt_d = retry_next;
            state_d     = S_BACKOFF;
         end else begin
            // fail is delayed one cycle so it never overlaps the error pulse
            retry_cnt_d = '0;
            fail_arm_d  = 1'b1;
            state_d     = S_IDLE;
         end
      end

      core_start_d = (state_d == S_START);
      busy_d       = (state_d != S_IDLE);
      fail_d       = fail_arm_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         ivl_cnt_q      <= '0;
         wait_cnt_q     <= '0;
         retry_cnt_q    <= '0;
         pending_q      <= 1'b0;
         frame_q        <= '0;
         fail_arm_q     <= 1'b0;
         core_start_q   <= 1'b0;
         humidity_q     <= '0;
         temperature_q  <= '0;
         sample_valid_q <= 1'b0;
         data_ok_q      <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_csum_q     <= 1'b0;
         fail_q         <= 1'b0;
         err_count_q    <= '0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ivl_cnt_q      <= ivl_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         retry_cnt_q    <= retry_cnt_d;
         pending_q      <= pending_d;
         frame_q        <= frame_d;
         fail_arm_q     <= fail_arm_d;
         core_start_q   <= core_start_d;
         humidity_q     <= humidity_d;
         temperature_q  <= temperature_d;
         sample_valid_q <= sample_valid_d;
         data_ok_q      <= data_ok_d;
         err_timeout_q  <= err_timeout_d;
         err_csum_q     <= err_csum_d;
         fail_q         <= fail_d;
         err_count_q    <= err_count_d;
         busy_q         <= busy_d;
      end
   end

   assign core_start   = core_start_q;
   assign humidity     = humidity_q;
   assign temperature  = temperature_q;
   assign sample_valid = sample_valid_q;
   assign data_ok      = data_ok_q;
   assign err_timeout  = err_timeout_q;
   assign err_csum     = err_csum_q;
   assign fail         = fail_q;
   assign err_count    = err_count_q;
   assign busy         = busy_q;

endmodule
